dircc_mailbox_tx: RTL
=====================

// Module: dircc_mailbox_tx
// PURPOSE
//  Host-side packet injector: the transmitter feeding a processing node's Avalon-ST packet input.
//  Host assembles a packet 16 bits at a time via the memory-mapped port, then commits it.
//  The block streams committed packets out as PACKET_WORDS full 32-bit beats.
//  Double-buffered: host fills one slot while the other is streamed.
// PARAMETERS
//  BITS_PER_SYMBOL   8   bits per Avalon-ST symbol
//  SYMBOLS_PER_BEAT  4   symbols per beat; DATA_WIDTH = 32
//  PACKET_WORDS      4   beats per packet (packet_t width / DATA_WIDTH), >= 2
//  MEM_WIDTH         16  host data width
//  ADDRESS_WIDTH     15  host word-address width
// PORTS
//  clk                   in   1   clock
//  reset_n               in   1   async active-low reset
//  mem_address           in   15  host word address
//  mem_write             in   1   host write strobe
//  mem_writedata         in   16  host write data
//  mem_readdata          out  16  host read data, registered
//  output_data           out  32  Avalon-ST data; beat 0 = packet bits [31:0]
//  output_empty          out  2   always 0
//  output_startofpacket  out  1   first beat
//  output_endofpacket    out  1   last beat
//  output_valid          out  1   beat valid
//  output_ready          in   1   sink ready, readyLatency 0
//  tx_idle               out  1   no full slot and not streaming
// BEHAVIOUR
//  Reset: all outputs 0 except tx_idle=1; both slots empty, fill_ptr=send_ptr=0, overflow=0.
//  Payload region: addr < 2*PACKET_WORDS; word=addr>>1; addr[0]=0 low half, 1 high half.
//  Payload writes land in slot[fill_ptr] only if it is empty; otherwise drop and set overflow.
//  Other addresses below STATS_ADDR: writes ignored, reads return 0.
//  CTRL_ADDR write: bit0 = commit, bit1 = clear overflow.
//  Commit while fill slot empty: mark it full, toggle fill_ptr. Otherwise: ignore, set overflow.
//  Read of CTRL_ADDR (status): [1:0] free slots (0..2), [2] streaming, [3] overflow.
//  Payload reads return the fill slot's halfword.
//  mem_readdata is registered from the previous cycle's mem_address (1-cycle latency).
//  TX FSM IDLE: slot[send_ptr] full -> SEND with beat=0; output_valid registered, asserted next cycle.
//  TX FSM SEND: output_valid=1, data=slot[send_ptr][beat].
//    sop = (beat==0); eop = (beat==PACKET_WORDS-1).
//    data/sop/eop are held stable while !output_ready.
//    On valid&&ready: beat++. On the last beat: free slot, toggle send_ptr.
//    If the other slot is full, continue back-to-back with its beat 0 (no bubble); else IDLE.
//  Same-cycle commit and last-beat release: both apply; free count stays consistent.
//  Commit of the slot just released in that cycle is legal.
//  Async reset mid-packet: valid drops immediately; partial packet is abandoned.
//    Downstream shares reset_n.
//  tx_idle = (state==IDLE) && both slots empty.
// CONFIGURATION
//  DIRCC_MAILBOX_TX_STATS_EN defined:
//    16-bit saturating count of completed packets (eop handshakes), readable at STATS_ADDR.
//    CTRL bit2 write clears it.
//  DIRCC_MAILBOX_TX_STATS_EN undefined: no counter; STATS_ADDR reads 0; CTRL bit2 ignored.
// STRUCTURE
//  dircc_types_pkg: CTRL_ADDR='h7FFF, STATS_ADDR='h7FFE.
//  dircc_types_pkg: mailbox_status_t packed struct; tx_state_t enum {TX_IDLE, TX_SEND}.
//  Sub-module dircc_mailbox_slot: one packet buffer with halfword write port, beat read port
//    and full flag. Instantiated twice.
// TESTING
//  Write 8 halfwords 0x0001..0x0008, commit -> 4 beats 0x00020001,0x00040003,0x00060005,0x00080007.
//    sop on beat0, eop on beat3, empty=0.
//  Hold output_ready=0 for 5 cycles mid-packet -> data/sop/eop unchanged.
//    Beat count is still 4 once ready returns.
//  Commit A and B with ready=1 -> 8 consecutive valid beats, no bubble between A eop and B sop.
//    Status free count = 2 afterwards.
//  ready=0, commit A, commit B, third commit and payload write -> dropped.
//    Status=0b1000 (free=0, overflow=1); A then B transmit unchanged; CTRL bit1 clears overflow.
//  Reset asserted on beat 2 -> valid=0 same cycle, tx_idle=1, free=2.
//    Next commit streams from sop.
//  With DIRCC_MAILBOX_TX_STATS_EN: send 3 packets -> STATS_ADDR reads 3.
//    Without: STATS_ADDR reads 0.

Source files
------------

// File: rtl/dircc_types_pkg.sv
// Shared constants and types for the DIRCC mailbox transmitter.
// Host map: payload halfwords at the bottom, STATS_ADDR and CTRL_ADDR at the top.
package dircc_types_pkg;

  localparam int BITS_PER_SYMBOL  = 8;
  localparam int SYMBOLS_PER_BEAT = 4;
  localparam int DATA_WIDTH       = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;
  localparam int PACKET_WORDS     = 4;
  localparam int MEM_WIDTH        = 16;
  localparam int ADDRESS_WIDTH    = 15;

  localparam logic [ADDRESS_WIDTH-1:0] CTRL_ADDR  = 15'h7FFF;
  localparam logic [ADDRESS_WIDTH-1:0] STATS_ADDR = 15'h7FFE;

  typedef enum logic {
    TX_IDLE,
    TX_SEND
  } tx_state_t;

  typedef struct packed {
    logic [11:0] rsvd;
    logic        overflow;
    logic        streaming;
    logic [1:0]  free;
  } mailbox_status_t;

  function automatic logic [1:0] free_count(input logic [1:0] full);
    case (full)
      2'b00:   return 2'd2;
      2'b11:   return 2'd0;
      default: return 2'd1;
    endcase
  endfunction

endpackage

// File: rtl/dircc_mailbox_slot.sv
// One packet buffer: halfword write port, whole-packet read view and a full flag.
// Set of the full flag wins over a same-cycle clear (re-commit of a just-released slot).
module dircc_mailbox_slot #(
  parameter int PACKET_WORDS = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_WIDTH    = 16,
  parameter int HALF_IDX_W   = $clog2(2 * PACKET_WORDS)
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             wr_en_i,
  input  logic [HALF_IDX_W-1:0]            wr_idx_i,
  input  logic [MEM_WIDTH-1:0]             wr_data_i,
  input  logic                             set_full_i,
  input  logic                             clr_full_i,
  output logic [PACKET_WORDS*DATA_WIDTH-1:0] pkt_o,
  output logic                             full_o
);

  logic [PACKET_WORDS*DATA_WIDTH-1:0] pkt_q;
  logic                               full_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      if (wr_en_i) pkt_q[wr_idx_i*MEM_WIDTH +: MEM_WIDTH] <= wr_data_i;
      if (set_full_i)      full_q <= 1'b1;
      else if (clr_full_i) full_q <= 1'b0;
    end
  end

  assign pkt_o  = pkt_q;
  assign full_o = full_q;

endmodule

// File: rtl/dircc_mailbox_tx.sv
// Host-side double-buffered packet injector streaming committed packets on Avalon-ST.
// Optional DIRCC_MAILBOX_TX_STATS_EN adds a saturating completed-packet counter at STATS_ADDR.
import dircc_types_pkg::*;

module dircc_mailbox_tx #(
  parameter int BITS_PER_SYMBOL  = dircc_types_pkg::BITS_PER_SYMBOL,
  parameter int SYMBOLS_PER_BEAT = dircc_types_pkg::SYMBOLS_PER_BEAT,
  parameter int PACKET_WORDS     = dircc_types_pkg::PACKET_WORDS,
  parameter int MEM_WIDTH        = dircc_types_pkg::MEM_WIDTH,
  parameter int ADDRESS_WIDTH    = dircc_types_pkg::ADDRESS_WIDTH
) (
  input  logic                                      clk,
  input  logic                                      reset_n,
  input  logic [ADDRESS_WIDTH-1:0]                  mem_address,
  input  logic                                      mem_write,
  input  logic [MEM_WIDTH-1:0]                      mem_writedata,
  output logic [MEM_WIDTH-1:0]                      mem_readdata,
  output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] output_data,
  output logic [1:0]                                output_empty,
  output logic                                      output_startofpacket,
  output logic                                      output_endofpacket,
  output logic                                      output_valid,
  input  logic                                      output_ready,
  output logic                                      tx_idle
);

  localparam int DW     = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;
  localparam int HALVES = 2 * PACKET_WORDS;
  localparam int HIW    = $clog2(HALVES);
  localparam int BW     = $clog2(PACKET_WORDS);
  localparam int PKT_W  = PACKET_WORDS * DW;
  localparam logic [BW-1:0] LAST_BEAT = BW'(PACKET_WORDS - 1);

  tx_state_t       state_q;
  logic [BW-1:0]   beat_q;
  logic            send_ptr_q, fill_ptr_q, overflow_q;
  logic            valid_q, sop_q, eop_q;
  logic [DW-1:0]   data_q;
  logic [MEM_WIDTH-1:0] rdata_q, rdata_d;

  logic [PKT_W-1:0] pkt0, pkt1, fill_pkt, send_pkt, other_pkt;
  logic [1:0]       full, rel, set;
  logic             is_payload, is_ctrl, pay_wr, commit, fill_free, wr_ok, commit_ok, drop;
  logic             last_hs, send_full, other_full;
  logic [BW-1:0]    next_beat;
  mailbox_status_t  status;
  logic             unused_wdata;

  function automatic logic [DW-1:0] beat_of(input logic [PKT_W-1:0] p, input logic [BW-1:0] b);
    return p[b*DW +: DW];
  endfunction

  always_comb begin
    is_payload = mem_address < ADDRESS_WIDTH'(HALVES);
    is_ctrl    = mem_address == CTRL_ADDR;
    last_hs    = (state_q == TX_SEND) && output_ready && (beat_q == LAST_BEAT);
    rel[0]     = last_hs && !send_ptr_q;
    rel[1]     = last_hs && send_ptr_q;
    // A slot being released this cycle already counts as free for the host.
    fill_free  = !full[fill_ptr_q] || rel[fill_ptr_q];
    pay_wr     = mem_write && is_payload;
    commit     = mem_write && is_ctrl && mem_writedata[0];
    wr_ok      = pay_wr && fill_free;
    commit_ok  = commit && fill_free;
    drop       = (pay_wr || commit) && !fill_free;
    set[0]     = commit_ok && !fill_ptr_q;
    set[1]     = commit_ok && fill_ptr_q;
    fill_pkt   = fill_ptr_q ? pkt1 : pkt0;
    send_pkt   = send_ptr_q ? pkt1 : pkt0;
    other_pkt  = send_ptr_q ? pkt0 : pkt1;
    send_full  = send_ptr_q ? full[1] : full[0];
    other_full = send_ptr_q ? full[0] : full[1];
    next_beat  = beat_q + 1'b1;
  end

  dircc_mailbox_slot #(.PACKET_WORDS(PACKET_WORDS), .DATA_WIDTH(DW), .MEM_WIDTH(MEM_WIDTH)) u_slot0 (
    .clk(clk), .reset_n(reset_n),
    .wr_en_i(wr_ok && !fill_ptr_q), .wr_idx_i(mem_address[HIW-1:0]), .wr_data_i(mem_writedata),
    .set_full_i(set[0]), .clr_full_i(rel[0]), .pkt_o(pkt0), .full_o(full[0])
  );

  dircc_mailbox_slot #(.PACKET_WORDS(PACKET_WORDS), .DATA_WIDTH(DW), .MEM_WIDTH(MEM_WIDTH)) u_slot1 (
    .clk(clk), .reset_n(reset_n),
    .wr_en_i(wr_ok && fill_ptr_q), .wr_idx_i(mem_address[HIW-1:0]), .wr_data_i(mem_writedata),
    .set_full_i(set[1]), .clr_full_i(rel[1]), .pkt_o(pkt1), .full_o(full[1])
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= TX_IDLE;
      beat_q     <= '0;
      send_ptr_q <= 1'b0;
      valid_q    <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      data_q     <= '0;
    end else begin
      case (state_q)
        TX_IDLE: begin
          if (send_full) begin
            state_q <= TX_SEND;
            beat_q  <= '0;
            valid_q <= 1'b1;
            sop_q   <= 1'b1;
            eop_q   <= 1'b0;
            data_q  <= beat_of(send_pkt, '0);
          end
        end
        TX_SEND: begin
          if (output_ready) begin
            if (beat_q == LAST_BEAT) begin
              send_ptr_q <= ~send_ptr_q;
              beat_q     <= '0;
              eop_q      <= 1'b0;
              // Chain straight into the other slot when it is already waiting.
              if (other_full) begin
                sop_q  <= 1'b1;
                data_q <= beat_of(other_pkt, '0);
              end else begin
                state_q <= TX_IDLE;
                valid_q <= 1'b0;
                sop_q   <= 1'b0;
                data_q  <= '0;
              end
            end else begin
              beat_q <= next_beat;
              sop_q  <= 1'b0;
              eop_q  <= (next_beat == LAST_BEAT);
              data_q <= beat_of(send_pkt, next_beat);
            end
          end
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fill_ptr_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (commit_ok) fill_ptr_q <= ~fill_ptr_q;
      if (mem_write && is_ctrl && mem_writedata[1]) overflow_q <= 1'b0;
      if (drop) overflow_q <= 1'b1;
    end
  end

`ifdef DIRCC_MAILBOX_TX_STATS_EN
  logic [15:0] stats_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stats_q <= '0;
    end else if (mem_write && is_ctrl && mem_writedata[2]) begin
      stats_q <= '0;
    end else if (last_hs && (stats_q != 16'hFFFF)) begin
      stats_q <= stats_q + 16'd1;
    end
  end
`endif

  always_comb begin
    status           = '0;
    status.free      = free_count(full);
    status.streaming = valid_q && output_ready;
    status.overflow  = overflow_q;
    rdata_d          = '0;
    if (is_payload)   rdata_d = fill_pkt[mem_address[HIW-1:0]*MEM_WIDTH +: MEM_WIDTH];
    else if (is_ctrl) rdata_d = MEM_WIDTH'(status);
`ifdef DIRCC_MAILBOX_TX_STATS_EN
    else if (mem_address == STATS_ADDR) rdata_d = MEM_WIDTH'(stats_q);
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rdata_q <= '0;
    else          rdata_q <= rdata_d;
  end

  assign unused_wdata         = ^mem_writedata;
  assign mem_readdata         = rdata_q;
  assign output_data          = data_q;
  assign output_empty         = 2'b00;
  assign output_startofpacket = sop_q;
  assign output_endofpacket   = eop_q;
  assign output_valid         = valid_q;
  assign tx_idle              = (state_q == TX_IDLE) && (full == 2'b00);

endmodule
